// File: rtl/dpram_test_sequencer.sv
// rtl/dpram_test_sequencer.sv - dual-port RAM march sequencer: write A / read B, write ~B / read A
// Checks each read one cycle after issue and reports error count and first failing location.
module dpram_test_sequencer #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] SEED,
    output logic [ADDR_WIDTH-1:0] ADDR_A,
    output logic [ADDR_WIDTH-1:0] ADDR_B,
    output logic [DATA_WIDTH-1:0] DI_A,
    output logic [DATA_WIDTH-1:0] DI_B,
    output logic                  WE_A,
    output logic                  WE_B,
    output logic                  EN_A,
    output logic                  EN_B,
    input  logic [DATA_WIDTH-1:0] DO_A,
    input  logic [DATA_WIDTH-1:0] DO_B,
    input  logic                  DO_VALID_A,
    input  logic                  DO_VALID_B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [15:0]           ERR_COUNT,
    output logic [ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
    output logic                  FIRST_ERR_PORT
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_RD_B, S_DRAIN_B, S_WR_B, S_RD_A, S_DRAIN_A, S_DONE
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] s);
        return DATA_WIDTH'(a) ^ s;
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   seed_q, seed_d;
    logic [15:0]             err_count_q, err_count_d;
    logic                    first_flag_q, first_flag_d;
    logic [ADDR_WIDTH-1:0]   first_addr_q, first_addr_d;
    logic                    first_port_q, first_port_d;
    logic                    chk_a_q, chk_a_d, chk_b_q, chk_b_d;
    logic [ADDR_WIDTH-1:0]   chk_addr_a_q, chk_addr_a_d, chk_addr_b_q, chk_addr_b_d;
    logic                    en_a_q, en_a_d, we_a_q, we_a_d, en_b_q, en_b_d, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0]   di_a_q, di_a_d, di_b_q, di_b_d;
    logic                    err_a, err_b, last_addr;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        seed_d       = seed_q;
        err_count_d  = err_count_q;
        first_flag_d = first_flag_q;
        first_addr_d = first_addr_q;
        first_port_d = first_port_q;
        last_addr    = &addr_q;

        // A read visible on the registered outputs is checked on the following cycle.
        chk_a_d      = en_a_q & ~we_a_q;
        chk_b_d      = en_b_q & ~we_b_q;
        chk_addr_a_d = addr_a_q;
        chk_addr_b_d = addr_b_q;

        err_a = chk_a_q && (!DO_VALID_A || (DO_A != ~pat(chk_addr_a_q, seed_q)));
        err_b = chk_b_q && (!DO_VALID_B || (DO_B != pat(chk_addr_b_q, seed_q)));

        if (err_a || err_b) begin
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
            if (!first_flag_q) begin
                first_flag_d = 1'b1;
                first_addr_d = err_b ? chk_addr_b_q : chk_addr_a_q;
                first_port_d = err_b;
            end
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d      = S_WR_A;
                    addr_d       = '0;
                    seed_d       = SEED;
                    err_count_d  = '0;
                    first_flag_d = 1'b0;
                    first_addr_d = '0;
                    first_port_d = 1'b0;
                end
            end
            S_WR_A: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (last_addr) state_d = S_RD_B;
            end
            S_RD_B: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (last_addr) state_d = S_DRAIN_B;
            end
            S_DRAIN_B: state_d = S_WR_B;
            S_WR_B: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (last_addr) state_d = S_RD_A;
            end
            S_RD_A: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (last_addr) state_d = S_DRAIN_A;
            end
            S_DRAIN_A: state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase

        // RAM-side controls are derived from the next state so they register in step with it.
        en_a_d   = 1'b0;
        we_a_d   = 1'b0;
        addr_a_d = '0;
        di_a_d   = '0;
        en_b_d   = 1'b0;
        we_b_d   = 1'b0;
        addr_b_d = '0;
        di_b_d   = '0;
        unique case (state_d)
            S_WR_A: begin
                en_a_d   = 1'b1;
                we_a_d   = 1'b1;
                addr_a_d = addr_d;
                di_a_d   = pat(addr_d, seed_d);
            end
            S_RD_B: begin
                en_b_d   = 1'b1;
                addr_b_d = addr_d;
            end
            S_WR_B: begin
                en_b_d   = 1'b1;
                we_b_d   = 1'b1;
                addr_b_d = addr_d;
                di_b_d   = ~pat(addr_d, seed_d);
            end
            S_RD_A: begin
                en_a_d   = 1'b1;
                addr_a_d = addr_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            seed_q       <= '0;
            err_count_q  <= '0;
            first_flag_q <= 1'b0;
            first_addr_q <= '0;
            first_port_q <= 1'b0;
            chk_a_q      <= 1'b0;
            chk_b_q      <= 1'b0;
            chk_addr_a_q <= '0;
            chk_addr_b_q <= '0;
            en_a_q       <= 1'b0;
            we_a_q       <= 1'b0;
            addr_a_q     <= '0;
            di_a_q       <= '0;
            en_b_q       <= 1'b0;
            we_b_q       <= 1'b0;
            addr_b_q     <= '0;
            di_b_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            seed_q       <= seed_d;
            err_count_q  <= err_count_d;
            first_flag_q <= first_flag_d;
            first_addr_q <= first_addr_d;
            first_port_q <= first_port_d;
            chk_a_q      <= chk_a_d;
            chk_b_q      <= chk_b_d;
            chk_addr_a_q <= chk_addr_a_d;
            chk_addr_b_q <= chk_addr_b_d;
            en_a_q       <= en_a_d;
            we_a_q       <= we_a_d;
            addr_a_q     <= addr_a_d;
            di_a_q       <= di_a_d;
            en_b_q       <= en_b_d;
            we_b_q       <= we_b_d;
            addr_b_q     <= addr_b_d;
            di_b_q       <= di_b_d;
        end
    end

    assign ADDR_A         = addr_a_q;
    assign ADDR_B         = addr_b_q;
    assign DI_A           = di_a_q;
    assign DI_B           = di_b_q;
    assign WE_A           = we_a_q;
    assign WE_B           = we_b_q;
    assign EN_A           = en_a_q;
    assign EN_B           = en_b_q;
    assign BUSY           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign DONE           = (state_q == S_DONE);
    assign PASS           = (state_q == S_DONE) && (err_count_q == 16'd0);
    assign ERR_COUNT      = err_count_q;
    assign FIRST_ERR_ADDR = first_addr_q;
    assign FIRST_ERR_PORT = first_port_q;

endmodule

// File: tb/tb_dpram_test_sequencer.sv
// tb/tb_dpram_test_sequencer.sv - scoreboard bench for dpram_test_sequencer
module tb_dpram_test_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, start1;
    logic [7:0] seed;
    logic [3:0] addr_a, addr_b, faddr;
    logic [7:0] di_a, di_b, do_a, do_b;
    logic       we_a, we_b, en_a, en_b, dv_a, dv_b;
    logic       busy, done, pass, fport;
    logic [15:0] err;

    logic       a1_a, a1_b, d1_a, d1_b, w1_a, w1_b, e1_a, e1_b;
    logic       busy1, done1, pass1, faddr1, fport1;
    logic [15:0] err1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fault = 0;
    int done_cnt = 0;
    logic mon_en = 1'b0;
    logic done_prev = 1'b0;
    logic [7:0] mem [16];

    typedef struct {logic port; logic we; logic [3:0] addr; logic [7:0] data;} iss_t;
    typedef struct {int cyc; logic pass; logic [15:0] err; logic [3:0] faddr; logic fport;} done_t;
    iss_t  iss_q[$];
    done_t done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dpram_test_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK(clk), .RST(rst), .START(start), .SEED(seed),
        .ADDR_A(addr_a), .ADDR_B(addr_b), .DI_A(di_a), .DI_B(di_b),
        .WE_A(we_a), .WE_B(we_b), .EN_A(en_a), .EN_B(en_b),
        .DO_A(do_a), .DO_B(do_b), .DO_VALID_A(dv_a), .DO_VALID_B(dv_b),
        .BUSY(busy), .DONE(done), .PASS(pass), .ERR_COUNT(err),
        .FIRST_ERR_ADDR(faddr), .FIRST_ERR_PORT(fport)
    );

    dpram_test_sequencer #(.DATA_WIDTH(1), .ADDR_WIDTH(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .SEED(1'b0),
        .ADDR_A(a1_a), .ADDR_B(a1_b), .DI_A(d1_a), .DI_B(d1_b),
        .WE_A(w1_a), .WE_B(w1_b), .EN_A(e1_a), .EN_B(e1_b),
        .DO_A(1'b0), .DO_B(1'b0), .DO_VALID_A(1'b0), .DO_VALID_B(1'b0),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_COUNT(err1),
        .FIRST_ERR_ADDR(faddr1), .FIRST_ERR_PORT(fport1)
    );

    // RAM model: fault 1 = bit 0 stuck at 0 on reads, fault 2 = no valid for port B read of address 3
    always @(posedge clk) begin
        dv_a <= en_a && !we_a;
        dv_b <= en_b && !we_b && !(fault == 2 && addr_b == 4'd3);
        do_a <= mem[addr_a] & ((fault == 1) ? 8'hFE : 8'hFF);
        do_b <= mem[addr_b] & ((fault == 1) ? 8'hFE : 8'hFF);
        if (en_a && we_a) mem[addr_a] <= di_a;
        if (en_b && we_b) mem[addr_b] <= di_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        iss_t e;
        done_t d;
        logic [12:0] act;
        logic [17:0] idle;
        if (mon_en) begin
            if (en_a || en_b) begin
                if (en_a && en_b) begin
                    chk("both_ports_enabled", 1, 0);
                end else if (iss_q.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    e = iss_q.pop_front();
                    act  = en_b ? {we_b, addr_b, di_b} : {we_a, addr_a, di_a};
                    idle = en_b ? {1'b0, en_a, we_a, addr_a, 4'd0, di_a}
                                : {1'b0, en_b, we_b, addr_b, 4'd0, di_b};
                    chk("issue_port", 32'(en_b), 32'(e.port));
                    chk("issue_we_addr_di", 32'(act), 32'({e.we, e.addr, e.data}));
                    chk("idle_port_zero", 32'(idle), 0);
                end
            end
            if (busy && done) chk("busy_and_done", 1, 0);
            if (done && !done_prev) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("pass", 32'(pass), 32'(d.pass));
                    chk("err_count", 32'(err), 32'(d.err));
                    chk("first_err_addr", 32'(faddr), 32'(d.faddr));
                    chk("first_err_port", 32'(fport), 32'(d.fport));
                end
            end
            done_prev = done;
        end
    end

    // Called at posedge+1; pulses START for one cycle and queues the expected run.
    task automatic start_run(input logic [7:0] s, input logic p, input logic [15:0] e,
                             input logic [3:0] fa, input logic fp);
        done_t d;
        for (int a = 0; a < 16; a++) iss_q.push_back('{1'b0, 1'b1, 4'(a), 8'(a) ^ s});
        for (int a = 0; a < 16; a++) iss_q.push_back('{1'b1, 1'b0, 4'(a), 8'h00});
        for (int a = 0; a < 16; a++) iss_q.push_back('{1'b1, 1'b1, 4'(a), ~(8'(a) ^ s)});
        for (int a = 0; a < 16; a++) iss_q.push_back('{1'b0, 1'b0, 4'(a), 8'h00});
        d = '{cyc + 67, p, e, fa, fp};
        done_q.push_back(d);
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n0 = done_cnt;
        for (int i = 0; i < 200 && done_cnt == n0; i++) @(posedge clk);
        #1;
        chk("done_timeout", 32'(done_cnt != n0), 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({busy, done, pass, fport, faddr, en_a, we_a, en_b, we_b}), 0);
        chk({name, "_err"}, 32'(err), 0);
        chk({name, "_ram"}, 32'({addr_a, addr_b, di_a, di_b}), 0);
    endtask

    initial begin
        int c1;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; seed = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        mon_en = 1'b1;
        rst = 1'b0;

        // start in the first cycle after reset, good RAM, seed A5
        start_run(8'hA5, 1'b1, 16'd0, 4'd0, 1'b0);
        wait_done();

        // bit 0 stuck at 0: 8 odd expected values per read phase
        fault = 1;
        start_run(8'hA5, 1'b0, 16'd16, 4'd0, 1'b1);
        wait_done();

        // missing valid on port B read of address 3
        fault = 2;
        start_run(8'hA5, 1'b0, 16'd1, 4'd3, 1'b1);
        wait_done();

        // START during RD_B is ignored; timing stays at c+67
        fault = 1;
        start_run(8'hA5, 1'b0, 16'd16, 4'd0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        // START in DONE restarts at once with errors cleared
        fault = 0;
        start_run(8'h3C, 1'b1, 16'd0, 4'd0, 1'b0);
        chk("restart_err_cleared", 32'(err), 0);
        chk("restart_busy", 32'({busy, done}), 32'b10);
        wait_done();

        // reset during WR_B (cycles c+34..c+49)
        start_run(8'h5A, 1'b1, 16'd0, 4'd0, 1'b0);
        repeat (39) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("midrun_reset");
        iss_q.delete();
        done_q.delete();
        rst = 1'b0;
        start_run(8'h5A, 1'b1, 16'd0, 4'd0, 1'b0);
        wait_done();

        // 1-bit RAM, 2 words, reads never valid: every one of 4 reads fails
        c1 = cyc;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int i = 0; i < 40 && !done1; i++) begin
            @(posedge clk); #1;
        end
        chk("w1_done_cycle", cyc, c1 + 11);
        chk("w1_err_count", 32'(err1), 4);
        chk("w1_first", 32'({pass1, fport1, faddr1}), 32'b010);

        chk("scoreboard_empty", 32'(iss_q.size() + done_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
